core_mem_arbiter: RTL and testbench

//  Shares one memory request port between the core's instruction and data interfaces (i_req_*/d_req_*).

---
 rtl/core_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_core_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Arbitrates one memory request port between instruction fetch and data access.
// Data has priority, a saturating streak counter protects fetch, and a grant locks until the memory acks.
module core_mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req_val,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ack,
    output logic [31:0] i_ack_rdata,

    input  logic        d_req_val,
    input  logic [31:0] d_req_addr,
    input  logic [2:0]  d_req_cop,
    input  logic [31:0] d_req_wdata,
    input  logic [2:0]  d_req_size,
    output logic        d_req_ack,
    output logic [31:0] d_ack_rdata,

    output logic        m_req_val,
    output logic [31:0] m_req_addr,
    output logic [2:0]  m_req_cop,
    output logic [31:0] m_req_wdata,
    output logic [2:0]  m_req_size,
    input  logic        m_req_ack,
    input  logic [31:0] m_ack_rdata,

    output logic [1:0]  arb_owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10
    } state_t;

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_I      = 2'b01;
    localparam logic [1:0] OWN_D      = 2'b10;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [2:0] COP_RD     = 3'b000;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    state_t      state;
    logic [3:0]  d_streak;
    logic [1:0]  owner;
    logic        grant_d;
    logic        grant_i;
    logic        xfer_done;

    function automatic logic [3:0] streak_sat_inc(input logic [3:0] cnt);
        return (cnt >= STREAK_MAX) ? STREAK_MAX : cnt + 4'd1;
    endfunction

    // Grant decision in IDLE is combinational so a request is presented to memory in its first cycle.
    always_comb begin
        grant_d = d_req_val && !(i_req_val && (d_streak == STREAK_MAX));
        grant_i = !grant_d && i_req_val;
        owner   = OWN_NONE;
        unique case (state)
            IDLE:    owner = grant_d ? OWN_D : (grant_i ? OWN_I : OWN_NONE);
            I_BUSY:  owner = OWN_I;
            D_BUSY:  owner = OWN_D;
            default: owner = OWN_NONE;
        endcase
        if (!rst_n) begin
            owner = OWN_NONE;
        end
    end

    assign m_req_val = (owner != OWN_NONE);
    assign arb_owner = owner;
    assign xfer_done = m_req_val && m_req_ack;

    assign i_req_ack   = xfer_done && (owner == OWN_I);
    assign d_req_ack   = xfer_done && (owner == OWN_D);
    assign i_ack_rdata = m_ack_rdata;
    assign d_ack_rdata = m_ack_rdata;

    always_comb begin
        m_req_addr  = 32'd0;
        m_req_cop   = COP_RD;
        m_req_wdata = 32'd0;
        m_req_size  = 3'b000;
        if (owner == OWN_D) begin
            m_req_addr  = d_req_addr;
            m_req_cop   = d_req_cop;
            m_req_wdata = d_req_wdata;
            m_req_size  = d_req_size;
        end else if (owner == OWN_I) begin
            m_req_addr  = i_req_addr;
            m_req_size  = SIZE_WORD;
        end
    end

    // A grant that is not acked in its first cycle locks the owner until the ack arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            d_streak <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (owner == OWN_D && !m_req_ack) begin
                        state <= D_BUSY;
                    end else if (owner == OWN_I && !m_req_ack) begin
                        state <= I_BUSY;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (m_req_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (xfer_done) begin
                if (owner == OWN_D && i_req_val) begin
                    d_streak <= streak_sat_inc(d_streak);
                end else begin
                    d_streak <= 4'd0;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A locked owner must hold its request until the ack; dropping it is a requester bug.
    always @(posedge clk) begin
        if (rst_n && state == I_BUSY) begin
            assert (i_req_val) else $error("i_req_val dropped while instr owns the port");
        end
        if (rst_n && state == D_BUSY) begin
            assert (d_req_val) else $error("d_req_val dropped while data owns the port");
        end
    end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: expected transactions are queued as requests are driven
// and compared when the arbiter forwards the memory ack.
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_val;
    logic [31:0] i_req_addr;
    logic        i_req_ack;
    logic [31:0] i_ack_rdata;
    logic        d_req_val;
    logic [31:0] d_req_addr;
    logic [2:0]  d_req_cop;
    logic [31:0] d_req_wdata;
    logic [2:0]  d_req_size;
    logic        d_req_ack;
    logic [31:0] d_ack_rdata;
    logic        m_req_val;
    logic [31:0] m_req_addr;
    logic [2:0]  m_req_cop;
    logic [31:0] m_req_wdata;
    logic [2:0]  m_req_size;
    logic        m_req_ack;
    logic [31:0] m_ack_rdata;
    logic [1:0]  arb_owner;

    localparam logic [31:0] RD_KEY = 32'h5A5A_5A5A;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat      = 0;
    logic ack_force;
    int   wait_cnt;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] addr;
        logic [2:0]  cop;
        logic [31:0] wdata;
        logic [2:0]  size;
    } exp_t;
    exp_t sb_q[$];

    core_mem_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_val(i_req_val), .i_req_addr(i_req_addr),
        .i_req_ack(i_req_ack), .i_ack_rdata(i_ack_rdata),
        .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
        .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
        .d_req_ack(d_req_ack), .d_ack_rdata(d_ack_rdata),
        .m_req_val(m_req_val), .m_req_addr(m_req_addr), .m_req_cop(m_req_cop),
        .m_req_wdata(m_req_wdata), .m_req_size(m_req_size),
        .m_req_ack(m_req_ack), .m_ack_rdata(m_ack_rdata),
        .arb_owner(arb_owner)
    );

    always #5 clk = ~clk;

    // Memory model: acks after lat wait cycles; read data is a fixed function of the address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wait_cnt <= 0;
        else if (!m_req_val || m_req_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end
    assign m_req_ack   = ack_force | (m_req_val && (wait_cnt >= lat));
    assign m_ack_rdata = m_req_addr ^ RD_KEY;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] own, input logic [31:0] addr, input logic [2:0] cop,
                            input logic [31:0] wdata, input logic [2:0] size);
        exp_t e;
        e.owner = own; e.addr = addr; e.cop = cop; e.wdata = wdata; e.size = size;
        sb_q.push_back(e);
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every forwarded ack must match the oldest queued transaction.
    always @(negedge clk) begin
        if (rst_n && (i_req_ack || d_req_ack)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_ack", 64'(arb_owner), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_owner", 64'(arb_owner), 64'(e.owner));
                check_eq("sb_iack",  64'(i_req_ack), 64'(e.owner == 2'b01));
                check_eq("sb_dack",  64'(d_req_ack), 64'(e.owner == 2'b10));
                check_eq("sb_addr",  64'(m_req_addr), 64'(e.addr));
                check_eq("sb_cop",   64'(m_req_cop), 64'(e.cop));
                check_eq("sb_wdata", 64'(m_req_wdata), 64'(e.wdata));
                check_eq("sb_size",  64'(m_req_size), 64'(e.size));
                check_eq("sb_rdata", 64'(e.owner == 2'b01 ? i_ack_rdata : d_ack_rdata),
                         64'(e.addr ^ RD_KEY));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_own;
        rst_n = 1'b0; ack_force = 1'b0;
        i_req_val = 1'b0; i_req_addr = 32'h0;
        d_req_val = 1'b0; d_req_addr = 32'h0; d_req_cop = 3'b0; d_req_wdata = 32'h0; d_req_size = 3'b0;

        // Reset with both requesters active and a spurious memory ack.
        i_req_val = 1'b1; d_req_val = 1'b1; ack_force = 1'b1;
        i_req_addr = 32'h80; d_req_addr = 32'h90;
        repeat (2) @(negedge clk);
        check_eq("rst_mval",  64'(m_req_val), 64'(0));
        check_eq("rst_iack",  64'(i_req_ack), 64'(0));
        check_eq("rst_dack",  64'(d_req_ack), 64'(0));
        check_eq("rst_owner", 64'(arb_owner), 64'(0));
        next_drive();
        i_req_val = 1'b0; d_req_val = 1'b0; ack_force = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_owner", 64'(arb_owner), 64'(0));

        // Memory ack with no request outstanding is ignored.
        next_drive();
        ack_force = 1'b1;
        @(negedge clk);
        check_eq("spur_iack", 64'(i_req_ack), 64'(0));
        check_eq("spur_dack", 64'(d_req_ack), 64'(0));
        check_eq("spur_mval", 64'(m_req_val), 64'(0));
        next_drive();
        ack_force = 1'b0;
        @(negedge clk);
        check_eq("spur_after_owner", 64'(arb_owner), 64'(0));

        // Instruction fetch acked in its grant cycle.
        next_drive();
        lat = 0; i_req_val = 1'b1; i_req_addr = 32'h100;
        push_exp(2'b01, 32'h100, 3'b000, 32'h0, 3'b010);
        @(negedge clk);
        check_eq("i0_mval", 64'(m_req_val), 64'(1));
        check_eq("i0_addr", 64'(m_req_addr), 64'h100);
        check_eq("i0_cop",  64'(m_req_cop), 64'(0));
        check_eq("i0_iack", 64'(i_req_ack), 64'(1));
        check_eq("i0_dack", 64'(d_req_ack), 64'(0));
        next_drive();
        i_req_val = 1'b0;

        // Both requesting, 3-cycle memory: data first, locked, then instr from IDLE.
        lat = 2;
        i_req_val = 1'b1; i_req_addr = 32'h200;
        d_req_val = 1'b1; d_req_addr = 32'h3000; d_req_cop = 3'b000; d_req_wdata = 32'h11; d_req_size = 3'b010;
        push_exp(2'b10, 32'h3000, 3'b000, 32'h11, 3'b010);
        push_exp(2'b01, 32'h200, 3'b000, 32'h0, 3'b010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("both_d_owner", 64'(arb_owner), 64'(2'b10));
            check_eq("both_d_mval",  64'(m_req_val), 64'(1));
            check_eq("both_d_dack",  64'(d_req_ack), 64'(k == 2));
            check_eq("both_d_iack",  64'(i_req_ack), 64'(0));
            next_drive();
        end
        d_req_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("both_i_owner", 64'(arb_owner), 64'(2'b01));
            check_eq("both_i_wdata", 64'(m_req_wdata), 64'(0));
            check_eq("both_i_iack",  64'(i_req_ack), 64'(k == 2));
            next_drive();
        end
        i_req_val = 1'b0;

        // Zero-wait memory with both held: streak limit forces every fifth grant to instr.
        lat = 0;
        i_req_val = 1'b1; i_req_addr = 32'h300;
        d_req_val = 1'b1; d_req_addr = 32'h3100; d_req_wdata = 32'h22;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) push_exp(2'b01, 32'h300, 3'b000, 32'h0, 3'b010);
            else            push_exp(2'b10, 32'h3100, 3'b000, 32'h22, 3'b010);
        end
        for (int k = 0; k < 10; k++) begin
            exp_own = (k % 5 == 4) ? 2'b01 : 2'b10;
            @(negedge clk);
            check_eq("streak_owner", 64'(arb_owner), 64'(exp_own));
            next_drive();
        end
        i_req_val = 1'b0; d_req_val = 1'b0;

        // Store passthrough; instr request arriving mid-transaction waits.
        lat = 2;
        d_req_val = 1'b1; d_req_addr = 32'h2004; d_req_cop = 3'b001; d_req_wdata = 32'hDEADBEEF; d_req_size = 3'b000;
        push_exp(2'b10, 32'h2004, 3'b001, 32'hDEADBEEF, 3'b000);
        @(negedge clk);
        check_eq("st_addr",  64'(m_req_addr), 64'h2004);
        check_eq("st_cop",   64'(m_req_cop), 64'(3'b001));
        check_eq("st_wdata", 64'(m_req_wdata), 64'hDEADBEEF);
        check_eq("st_size",  64'(m_req_size), 64'(0));
        next_drive();
        i_req_val = 1'b1; i_req_addr = 32'h400;
        push_exp(2'b01, 32'h400, 3'b000, 32'h0, 3'b010);
        @(negedge clk);
        check_eq("st_nopreempt_owner", 64'(arb_owner), 64'(2'b10));
        check_eq("st_nopreempt_addr",  64'(m_req_addr), 64'h2004);
        next_drive();
        @(negedge clk);
        check_eq("st_dack", 64'(d_req_ack), 64'(1));
        next_drive();
        d_req_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("st_i_owner", 64'(arb_owner), 64'(2'b01));
            check_eq("st_i_addr",  64'(m_req_addr), 64'h400);
            check_eq("st_i_size",  64'(m_req_size), 64'(3'b010));
            next_drive();
        end
        i_req_val = 1'b0;

        // Reset during a locked data transaction; pending fetch granted right after release.
        lat = 5;
        d_req_val = 1'b1; d_req_addr = 32'h5000; d_req_cop = 3'b000; d_req_size = 3'b010;
        i_req_val = 1'b1; i_req_addr = 32'h600;
        @(negedge clk);
        check_eq("mr_owner0", 64'(arb_owner), 64'(2'b10));
        next_drive();
        @(negedge clk);
        check_eq("mr_owner1", 64'(arb_owner), 64'(2'b10));
        #1 rst_n = 1'b0;
        #1;
        check_eq("mr_rst_mval",  64'(m_req_val), 64'(0));
        check_eq("mr_rst_owner", 64'(arb_owner), 64'(0));
        check_eq("mr_rst_dack",  64'(d_req_ack), 64'(0));
        d_req_val = 1'b0;
        next_drive();
        lat = 0; rst_n = 1'b1;
        push_exp(2'b01, 32'h600, 3'b000, 32'h0, 3'b010);
        @(negedge clk);
        check_eq("mr_rel_owner", 64'(arb_owner), 64'(2'b01));
        check_eq("mr_rel_iack",  64'(i_req_ack), 64'(1));
        next_drive();
        i_req_val = 1'b0;
        @(negedge clk);
        check_eq("mr_end_owner", 64'(arb_owner), 64'(0));

        check_eq("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
